// File: rtl/interrupt_ack_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_ack_sequencer
//
// Purpose:
//   Priority resolution and INTA sequencing for an 8259A-compatible PIC in
//   8086 mode. Picks the highest-priority pending request that beats the
//   in-service register, raises INT, runs the two-pulse INTA handshake,
//   tells the IRR which level to clear, emits the vector byte and handles
//   specific, non-specific and automatic EOI with optional rotation.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   pendingIRQ   in   [7:0] masked pending requests from the IRR
//   vectorBase   in   [4:0] ICW2 T7..T3
//   autoEOI      in   AEOI mode
//   rotateMode   in   rotate priority on every EOI
//   intaPulse    in   one-cycle strobe per INTA falling edge
//   eoiStrobe    in   one-cycle OCW2 EOI strobe
//   eoiSpecific  in   1 = specific EOI, 0 = non-specific
//   eoiLevel     in   [2:0] level cleared by a specific EOI
//   intOut       out  INT to the CPU (registered)
//   readPriority out  one-cycle pulse: IRR clears level resetIRR
//   resetIRR     out  [2:0] serviced level
//   vectorValid  out  one-cycle strobe: vectorData valid
//   vectorData   out  [7:0] {vectorBase, level}, held until next strobe
//   inService    out  [7:0] ISR contents
//
// Handshakes: readPriority and vectorValid are single-cycle valid strobes
// with no back-pressure; their data buses are meaningful on the strobe cycle.
// ---------------------------------------------------------------------------
module interrupt_ack_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pendingIRQ,
    input  logic [4:0] vectorBase,
    input  logic       autoEOI,
    input  logic       rotateMode,
    input  logic       intaPulse,
    input  logic       eoiStrobe,
    input  logic       eoiSpecific,
    input  logic [2:0] eoiLevel,
    output logic       intOut,
    output logic       readPriority,
    output logic [2:0] resetIRR,
    output logic       vectorValid,
    output logic [7:0] vectorData,
    output logic [7:0] inService
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       int_q, int_d;
    logic       rp_q, rp_d;
    logic [2:0] reset_irr_q, reset_irr_d;
    logic       vv_q, vv_d;
    logic [7:0] vdata_q, vdata_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] lowest_q, lowest_d;
    logic [2:0] level_q, level_d;
    logic       spur_q, spur_d;

    logic       isr_found;
    logic [2:0] isr_lvl;
    logic       win_found;
    logic [2:0] win_lvl;

    // Walk levels from highest to lowest priority. A request is eligible only
    // while no in-service level has been seen yet; checking the ISR bit first
    // also excludes a request at the same level as the highest ISR bit.
    always_comb begin
        logic [2:0] lvl;
        isr_found = 1'b0;
        isr_lvl   = 3'd0;
        win_found = 1'b0;
        win_lvl   = 3'd0;
        lvl       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            lvl = lowest_q + 3'(i + 1);
            if (!isr_found && isr_q[lvl]) begin
                isr_found = 1'b1;
                isr_lvl   = lvl;
            end
            if (!win_found && !isr_found && pendingIRQ[lvl]) begin
                win_found = 1'b1;
                win_lvl   = lvl;
            end
        end
    end

    always_comb begin
        logic [7:0] set_mask;
        logic [7:0] aeoi_mask;
        logic [7:0] eoi_mask;
        state_d     = state_q;
        int_d       = int_q;
        rp_d        = 1'b0;
        reset_irr_d = reset_irr_q;
        vv_d        = 1'b0;
        vdata_d     = vdata_q;
        lowest_d    = lowest_q;
        level_d     = level_q;
        spur_d      = spur_q;
        set_mask    = 8'h00;
        aeoi_mask   = 8'h00;
        eoi_mask    = 8'h00;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = REQ;
                    int_d   = 1'b1;
                end
            end
            REQ: begin
                // INTA takes precedence over a withdrawn request so that a
                // late withdrawal still completes as a spurious acknowledge.
                if (intaPulse) begin
                    state_d = ACK1;
                    int_d   = 1'b0;
                    if (win_found) begin
                        set_mask    = 8'h01 << win_lvl;
                        rp_d        = 1'b1;
                        reset_irr_d = win_lvl;
                        level_d     = win_lvl;
                        spur_d      = 1'b0;
                    end else begin
                        level_d = 3'd7;
                        spur_d  = 1'b1;
                    end
                end else if (!win_found) begin
                    state_d = IDLE;
                    int_d   = 1'b0;
                end
            end
            ACK1: begin
                if (intaPulse) begin
                    state_d = IDLE;
                    vv_d    = 1'b1;
                    vdata_d = {vectorBase, level_q};
                    if (autoEOI && !spur_q) begin
                        aeoi_mask = 8'h01 << level_q;
                        if (rotateMode) lowest_d = level_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
            end
        endcase

        // EOI works from the pre-edge ISR; a bit set by INTA1 on the same
        // edge therefore survives. An explicit EOI rotation overrides AEOI's.
        if (eoiStrobe) begin
            if (eoiSpecific) begin
                if (isr_q[eoiLevel]) begin
                    eoi_mask = 8'h01 << eoiLevel;
                    if (rotateMode) lowest_d = eoiLevel;
                end
            end else if (isr_found) begin
                eoi_mask = 8'h01 << isr_lvl;
                if (rotateMode) lowest_d = isr_lvl;
            end
        end

        isr_d = (isr_q & ~(aeoi_mask | eoi_mask)) | set_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            int_q       <= 1'b0;
            rp_q        <= 1'b0;
            reset_irr_q <= 3'd0;
            vv_q        <= 1'b0;
            vdata_q     <= 8'h00;
            isr_q       <= 8'h00;
            lowest_q    <= 3'd7;
            level_q     <= 3'd0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            int_q       <= int_d;
            rp_q        <= rp_d;
            reset_irr_q <= reset_irr_d;
            vv_q        <= vv_d;
            vdata_q     <= vdata_d;
            isr_q       <= isr_d;
            lowest_q    <= lowest_d;
            level_q     <= level_d;
            spur_q      <= spur_d;
        end
    end

    assign intOut       = int_q;
    assign readPriority = rp_q;
    assign resetIRR     = reset_irr_q;
    assign vectorValid  = vv_q;
    assign vectorData   = vdata_q;
    assign inService    = isr_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
module tb_interrupt_ack_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] pendingIRQ;
    logic [4:0] vectorBase;
    logic       autoEOI, rotateMode, intaPulse, eoiStrobe, eoiSpecific;
    logic [2:0] eoiLevel;
    logic       intOut, readPriority, vectorValid;
    logic [2:0] resetIRR;
    logic [7:0] vectorData, inService;

    interrupt_ack_sequencer dut (
        .clk(clk), .reset(reset), .pendingIRQ(pendingIRQ), .vectorBase(vectorBase),
        .autoEOI(autoEOI), .rotateMode(rotateMode), .intaPulse(intaPulse),
        .eoiStrobe(eoiStrobe), .eoiSpecific(eoiSpecific), .eoiLevel(eoiLevel),
        .intOut(intOut), .readPriority(readPriority), .resetIRR(resetIRR),
        .vectorValid(vectorValid), .vectorData(vectorData), .inService(inService)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [7:0] m_isr;
    int         m_lowest;
    logic [2:0] exp_q[$];      // expected resetIRR per readPriority strobe
    logic [7:0] exp_vec_q[$];  // expected vectorData per vectorValid strobe

    // 0 = highest priority, 7 = lowest
    function automatic int prio(input int lvl);
        return (lvl - m_lowest - 1 + 16) % 8;
    endfunction

    function automatic int m_highest_isr();
        int best = -1;
        for (int l = 0; l < 8; l++)
            if (m_isr[l] && (best < 0 || prio(l) < prio(best))) best = l;
        return best;
    endfunction

    function automatic int m_winner(input logic [7:0] pend);
        int h    = m_highest_isr();
        int best = -1;
        for (int l = 0; l < 8; l++)
            if (pend[l] && (h < 0 || prio(l) < prio(h)) && (best < 0 || prio(l) < prio(best)))
                best = l;
        return best;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [2:0] mon_e3;
    logic [7:0] mon_e8;
    always @(negedge clk) begin
        if (!reset) begin
            if (readPriority) begin
                if (exp_q.size() == 0) check("unexpected_readPriority", 1, 0);
                else begin
                    mon_e3 = exp_q.pop_front();
                    check("resetIRR", {29'd0, resetIRR}, {29'd0, mon_e3});
                end
            end
            if (vectorValid) begin
                if (exp_vec_q.size() == 0) check("unexpected_vectorValid", 1, 0);
                else begin
                    mon_e8 = exp_vec_q.pop_front();
                    check("vectorData", {24'd0, vectorData}, {24'd0, mon_e8});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_eoi(input logic spec, input logic [2:0] lvl);
        int h;
        eoiStrobe   = 1'b1;
        eoiSpecific = spec;
        eoiLevel    = lvl;
        if (spec) begin
            if (m_isr[lvl]) begin
                m_isr[lvl] = 1'b0;
                if (rotateMode) m_lowest = int'(lvl);
            end
        end else begin
            h = m_highest_isr();
            if (h >= 0) begin
                m_isr[h] = 1'b0;
                if (rotateMode) m_lowest = h;
            end
        end
        step();
        eoiStrobe = 1'b0;
        check("eoi_isr", {24'd0, inService}, {24'd0, m_isr});
    endtask

    // Full request/acknowledge; starts and ends in IDLE with pendingIRQ = 0.
    task automatic ack_seq(input logic [7:0] pend, input logic eoi_same);
        int w;
        w = m_winner(pend);
        pendingIRQ = pend;
        step();
        if (w < 0) begin
            check("int_blocked", {31'd0, intOut}, 0);
            step();
            check("int_blocked_hold", {31'd0, intOut}, 0);
            pendingIRQ = 8'h00;
            step();
            return;
        end
        check("int_rise", {31'd0, intOut}, 1);
        repeat ($urandom_range(0, 3)) step();
        check("int_held", {31'd0, intOut}, 1);
        intaPulse = 1'b1;
        exp_q.push_back(3'(w));
        // The winner is never already in service, so a same-edge specific
        // EOI for it clears nothing and the INTA1 set stands.
        if (eoi_same) begin
            eoiStrobe   = 1'b1;
            eoiSpecific = 1'b1;
            eoiLevel    = 3'(w);
        end
        m_isr[w] = 1'b1;
        step();
        intaPulse = 1'b0;
        eoiStrobe = 1'b0;
        check("inta1_int_low", {31'd0, intOut}, 0);
        check("inta1_isr", {24'd0, inService}, {24'd0, m_isr});
        pendingIRQ[w] = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        intaPulse = 1'b1;
        exp_vec_q.push_back({vectorBase, 3'(w)});
        if (autoEOI) begin
            m_isr[w] = 1'b0;
            if (rotateMode) m_lowest = w;
        end
        step();
        intaPulse = 1'b0;
        check("inta2_isr", {24'd0, inService}, {24'd0, m_isr});
        pendingIRQ = 8'h00;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; pendingIRQ = 8'h00; vectorBase = 5'h11;
        autoEOI = 1'b0; rotateMode = 1'b0; intaPulse = 1'b0;
        eoiStrobe = 1'b0; eoiSpecific = 1'b0; eoiLevel = 3'd0;
        m_isr = 8'h00; m_lowest = 7;
        #1;
        check("rst_intOut", {31'd0, intOut}, 0);
        check("rst_readPriority", {31'd0, readPriority}, 0);
        check("rst_vectorValid", {31'd0, vectorValid}, 0);
        check("rst_resetIRR", {29'd0, resetIRR}, 0);
        check("rst_vectorData", {24'd0, vectorData}, 0);
        check("rst_inService", {24'd0, inService}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // Basic acknowledge: IR3, vector 0x8B
        ack_seq(8'h08, 1'b0);
        check("basic_isr", {24'd0, inService}, 32'h08);
        // Nesting: IR4/IR5 blocked by IR3, IR2 nests
        ack_seq(8'h30, 1'b0);
        ack_seq(8'h04, 1'b0);
        check("nest_isr", {24'd0, inService}, 32'h0C);
        // Non-specific EOI with rotation clears IR2, lowest becomes 2
        rotateMode = 1'b1;
        do_eoi(1'b0, 3'd0);
        check("rot_isr", {24'd0, inService}, 32'h08);
        rotateMode = 1'b0;
        do_eoi(1'b1, 3'd3);
        ack_seq(8'h05, 1'b0);          // IR0 wins
        do_eoi(1'b0, 3'd0);

        // Withdrawn request, INTA in IDLE ignored
        pendingIRQ = 8'h40;
        step();
        check("wd_int_rise", {31'd0, intOut}, 1);
        pendingIRQ = 8'h00;
        step();
        check("wd_int_drop", {31'd0, intOut}, 0);
        intaPulse = 1'b1; step(); intaPulse = 1'b0; step();
        intaPulse = 1'b1; step(); intaPulse = 1'b0; step();
        // Spurious: withdrawal on the same edge as INTA1
        pendingIRQ = 8'h40;
        step();
        check("sp_int_rise", {31'd0, intOut}, 1);
        pendingIRQ = 8'h00;
        intaPulse = 1'b1;
        step();
        intaPulse = 1'b0;
        check("sp_int_low", {31'd0, intOut}, 0);
        check("sp_isr", {24'd0, inService}, {24'd0, m_isr});
        step();
        intaPulse = 1'b1;
        exp_vec_q.push_back({vectorBase, 3'd7});
        step();
        intaPulse = 1'b0;
        check("sp_isr_after", {24'd0, inService}, {24'd0, m_isr});
        step();

        // AEOI: bit 5 set after INTA1, cleared after INTA2
        autoEOI = 1'b1;
        ack_seq(8'h20, 1'b0);
        check("aeoi_isr", {24'd0, inService}, 32'h00);
        autoEOI = 1'b0;
        // Specific EOI on the INTA1 edge: set wins
        ack_seq(8'h20, 1'b1);
        check("eoi_same_edge_isr", {24'd0, inService}, 32'h20);
        do_eoi(1'b1, 3'd5);

        // Reset while in ACK1
        pendingIRQ = 8'h02;
        step();
        intaPulse = 1'b1;
        exp_q.push_back(3'd1);
        m_isr[1] = 1'b1;
        step();
        intaPulse = 1'b0;
        pendingIRQ = 8'h00;
        step();
        #2 reset = 1'b1;
        m_isr = 8'h00; m_lowest = 7;
        #1;
        check("mid_rst_intOut", {31'd0, intOut}, 0);
        check("mid_rst_readPriority", {31'd0, readPriority}, 0);
        check("mid_rst_vectorValid", {31'd0, vectorValid}, 0);
        check("mid_rst_resetIRR", {29'd0, resetIRR}, 0);
        check("mid_rst_vectorData", {24'd0, vectorData}, 0);
        check("mid_rst_inService", {24'd0, inService}, 0);
        #3 reset = 1'b0;
        step();
        intaPulse = 1'b1; step(); intaPulse = 1'b0; step();
        check("post_rst_int", {31'd0, intOut}, 0);
        ack_seq(8'h10, 1'b0);
        do_eoi(1'b0, 3'd0);

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            autoEOI    = 1'($urandom_range(0, 1));
            rotateMode = 1'($urandom_range(0, 1));
            vectorBase = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) < 6)
                ack_seq(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
            else
                do_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        step();
        check("rp_queue_drained", exp_q.size(), 0);
        check("vec_queue_drained", exp_vec_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

Interrupt acknowledge sequencer for the 8259A-compatible PIC. It sits directly downstream of the interrupt request register. It takes the masked, pending request vector and resolves priority against the in-service register (ISR). It raises INT, runs the two-pulse INTA sequence (8086 mode), returns the serviced level to the IRR for clearing, drives the vector byte, and processes EOI commands.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk` — in, 1 — system clock. All state updates on the rising edge.
- `reset` — in, 1 — asynchronous, active-high reset.
- `pendingIRQ` — in, 8 — pending, already-masked requests from the IRR. Bit n is IRn.
- `vectorBase` — in, 5 — ICW2 T7..T3.
- `autoEOI` — in, 1 — AEOI mode from ICW4.
- `rotateMode` — in, 1 — rotate priority on every EOI (specific, non-specific and AEOI).
- `intaPulse` — in, 1 — one-cycle strobe per INTA falling edge, already synchronised by control logic.
- `eoiStrobe` — in, 1 — one-cycle OCW2 EOI command strobe.
- `eoiSpecific` — in, 1 — 1 = specific EOI, 0 = non-specific EOI.
- `eoiLevel` — in, 3 — level to clear on a specific EOI.
- `intOut` — out, 1 — INT to the CPU, registered.
- `readPriority` — out, 1 — one-cycle pulse to the IRR: clear level `resetIRR`.
- `resetIRR` — out, 3 — serviced level. Valid while `readPriority` = 1.
- `vectorValid` — out, 1 — one-cycle strobe: `vectorData` is valid.
- `vectorData` — out, 8 — {`vectorBase`, level}. Holds its value until the next strobe.
- `inService` — out, 8 — ISR contents, for status reads.

## Operation
- Reset values:
  - `intOut`, `readPriority`, `vectorValid` = 0.
  - `resetIRR`, `vectorData`, `inService` = 0.
  - State = IDLE.
  - Lowest-priority pointer `lowest` = 7, so IR0 is highest.
- Priority order: `lowest`+1 (highest) … `lowest` (lowest), modulo 8.
- `highestISR` = highest-priority set bit of `inService`, or none.
- Eligible request: a set bit of `pendingIRQ` whose priority is strictly higher than `highestISR`, or any set bit if the ISR is empty (fully nested mode).
- `winner` = highest-priority eligible request.
- States:
  - IDLE: an eligible request exists → REQ, and `intOut` <= 1.
  - REQ:
    - No eligible request (request withdrawn or masked) → IDLE, `intOut` <= 0.
    - `intaPulse` → ACK1 and `intOut` <= 0. On the same edge:
      - A winner exists: `inService[winner]` <= 1, `readPriority` <= 1, `resetIRR` <= `winner`, and the latched level = `winner`.
      - No winner (spurious): latched level = 7. ISR unchanged, no `readPriority`.
  - ACK1: `intaPulse` → IDLE. On the same edge:
    - `vectorValid` <= 1 and `vectorData` <= {`vectorBase`, latched level}.
    - If `autoEOI` is set and the acknowledge was not spurious: clear `inService[latched level]`. If `rotateMode` is also set, `lowest` <= latched level.
  - `intaPulse` in IDLE is ignored.
- EOI is accepted in any state:
  - Non-specific: clears `highestISR`. No effect if the ISR is empty.
  - Specific: clears `inService[eoiLevel]`.
  - If `rotateMode` is set and a bit was cleared: `lowest` <= the cleared level.
- Simultaneous events:
  - EOI uses the ISR value from before the edge.
  - An ISR set (first INTA) and an EOI clear of the same bit on one edge: the set wins.
  - AEOI clear and an explicit EOI on the same edge: both are applied.
- `reset` asserted mid-sequence: all state and outputs return to reset values immediately (asynchronous). The sequence is abandoned; no vector is produced.

## Timing
- Eligible request visible at edge k → `intOut` = 1 after edge k.
- First `intaPulse` sampled at edge m → after edge m: `readPriority` = 1 for exactly one cycle, `inService` updated, `intOut` = 0.
- Second `intaPulse` sampled at edge p → after edge p: `vectorValid` = 1 for exactly one cycle.
- Earliest possible re-assertion of `intOut`: one cycle after returning to IDLE, i.e. after edge p+1.
- EOI takes effect on `inService` at the edge that samples `eoiStrobe`.

## Test plan
- Basic acknowledge:
  - Stimulus: `pendingIRQ`=0x08, `vectorBase`=0x11, then INTA, INTA.
  - Response: `intOut` rises; after INTA1, `readPriority`=1 with `resetIRR`=3 and `inService`=0x08; after INTA2, `vectorData`=0x8B with `vectorValid` pulsed once.
- Nesting:
  - Stimulus: with `inService`=0x08, raise `pendingIRQ`=0x30, then 0x04.
  - Response: 0x30 never raises `intOut`. 0x04 raises `intOut` and is acknowledged with level 2, giving `inService`=0x0C.
- EOI and rotation:
  - Stimulus: `inService`=0x0C, non-specific EOI with `rotateMode`=1.
  - Response: `inService`=0x08, `lowest`=2. Then `pendingIRQ`=0x05 with the ISR cleared → IR0 wins.
- Spurious acknowledge:
  - Stimulus: request withdrawn after `intOut` rises but before INTA1 is registered, then INTA pulses are forced.
  - Response: `intOut` drops with no request. Forced INTA, INTA from REQ with `pendingIRQ`=0 → vector {`vectorBase`,7}, `inService` unchanged, no `readPriority`.
- AEOI and simultaneous EOI:
  - Stimulus 1: `autoEOI`=1, acknowledge IR5.
  - Response 1: `inService` bit 5 set after INTA1, cleared after INTA2.
  - Stimulus 2: specific EOI for level 5 on the same edge as INTA1 for IR5.
  - Response 2: bit 5 remains set.
- Reset mid-sequence:
  - Stimulus: assert `reset` while in ACK1.
  - Response: immediately all outputs = 0 and state = IDLE. No `vectorValid` occurs after the following INTA.
